// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: operand bypass (EX/MEM/WB), load-use detection, stall/flush.
// Optional: define ID_EX_PERF_EN to add the perf_lu_cnt load-use stall counter output.
module id_ex_stage #(
    parameter int XLEN   = 32,
    parameter int CTRL_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [XLEN-1:0]   id_pc,
    input  logic [4:0]        id_rs1,
    input  logic [4:0]        id_rs2,
    input  logic              id_rs1_used,
    input  logic              id_rs2_used,
    input  logic [XLEN-1:0]   rf_rd1,
    input  logic [XLEN-1:0]   rf_rd2,
    input  logic [XLEN-1:0]   id_imm,
    input  logic [4:0]        id_rd,
    input  logic              id_rd_we,
    input  logic              id_is_load,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic [XLEN-1:0]   ex_alu_y,
    input  logic [4:0]        mem_rd,
    input  logic              mem_rd_we,
    input  logic [XLEN-1:0]   mem_wd,
    input  logic [4:0]        wb_rd,
    input  logic              wb_rd_we,
    input  logic [XLEN-1:0]   wb_wd,
    input  logic              ex_hold,
    input  logic              flush,
    output logic              stall,
    output logic              ex_valid,
    output logic              ex_rd_we,
    output logic              ex_is_load,
    output logic [XLEN-1:0]   ex_pc,
    output logic [XLEN-1:0]   ex_op1,
    output logic [XLEN-1:0]   ex_op2,
    output logic [XLEN-1:0]   ex_imm,
    output logic [4:0]        ex_rd,
    output logic [CTRL_W-1:0] ex_ctrl
`ifdef ID_EX_PERF_EN
    ,
    output logic [31:0]       perf_lu_cnt
`endif
);

    logic              r_valid;
    logic              r_rd_we;
    logic              r_is_load;
    logic [XLEN-1:0]   r_pc;
    logic [XLEN-1:0]   r_op1;
    logic [XLEN-1:0]   r_op2;
    logic [XLEN-1:0]   r_imm;
    logic [4:0]        r_rd;
    logic [CTRL_W-1:0] r_ctrl;

    logic [XLEN-1:0]   w_op1;
    logic [XLEN-1:0]   w_op2;
    logic              w_ex_fwd_en;
    logic              w_load_use;
    logic              w_stall;

    // Youngest producer wins; a load in EX has no data yet, so it never forwards from EX.
    function automatic logic [XLEN-1:0] f_resolve(
        input logic [4:0]      s,
        input logic [XLEN-1:0] rf,
        input logic            ex_en,
        input logic [4:0]      ex_d,
        input logic [XLEN-1:0] ex_v,
        input logic            mem_en,
        input logic [4:0]      mem_d,
        input logic [XLEN-1:0] mem_v,
        input logic            wb_en,
        input logic [4:0]      wb_d,
        input logic [XLEN-1:0] wb_v
    );
        logic [XLEN-1:0] y;
        if (s == 5'd0)                    y = '0;
        else if (ex_en && ex_d == s)      y = ex_v;
        else if (mem_en && mem_d == s)    y = mem_v;
        else if (wb_en && wb_d == s)      y = wb_v;
        else                              y = rf;
        return y;
    endfunction

    always_comb begin
        w_ex_fwd_en = r_valid & r_rd_we & ~r_is_load;
        w_op1 = f_resolve(id_rs1, rf_rd1, w_ex_fwd_en, r_rd, ex_alu_y,
                          mem_rd_we, mem_rd, mem_wd, wb_rd_we, wb_rd, wb_wd);
        w_op2 = f_resolve(id_rs2, rf_rd2, w_ex_fwd_en, r_rd, ex_alu_y,
                          mem_rd_we, mem_rd, mem_wd, wb_rd_we, wb_rd, wb_wd);
        w_load_use = id_valid & r_valid & r_is_load & r_rd_we & (r_rd != 5'd0) &
                     ((id_rs1_used & (id_rs1 == r_rd)) | (id_rs2_used & (id_rs2 == r_rd)));
        // rst gating keeps stall low while reset holds even if ex_hold is asserted.
        w_stall = rst & ~flush & (ex_hold | w_load_use);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid   <= 1'b0;
            r_rd_we   <= 1'b0;
            r_is_load <= 1'b0;
            r_pc      <= '0;
            r_op1     <= '0;
            r_op2     <= '0;
            r_imm     <= '0;
            r_rd      <= '0;
            r_ctrl    <= '0;
        end else if (flush || (!ex_hold && w_load_use)) begin
            r_valid   <= 1'b0;
            r_rd_we   <= 1'b0;
            r_is_load <= 1'b0;
            r_pc      <= '0;
            r_op1     <= '0;
            r_op2     <= '0;
            r_imm     <= '0;
            r_rd      <= '0;
            r_ctrl    <= '0;
        end else if (!ex_hold) begin
            r_valid   <= id_valid;
            r_rd_we   <= id_valid & id_rd_we;
            r_is_load <= id_valid & id_is_load;
            r_pc      <= id_pc;
            r_op1     <= w_op1;
            r_op2     <= w_op2;
            r_imm     <= id_imm;
            r_rd      <= id_rd;
            r_ctrl    <= id_ctrl;
        end
    end

`ifdef ID_EX_PERF_EN
    logic [31:0] r_perf_lu_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_perf_lu_cnt <= '0;
        else if (w_load_use && !flush && !ex_hold)
            r_perf_lu_cnt <= r_perf_lu_cnt + 32'd1;
    end

    assign perf_lu_cnt = r_perf_lu_cnt;
`endif

    assign stall      = w_stall;
    assign ex_valid   = r_valid;
    assign ex_rd_we   = r_rd_we;
    assign ex_is_load = r_is_load;
    assign ex_pc      = r_pc;
    assign ex_op1     = r_op1;
    assign ex_op2     = r_op2;
    assign ex_imm     = r_imm;
    assign ex_rd      = r_rd;
    assign ex_ctrl    = r_ctrl;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed hazard/bypass scenarios plus random traffic vs. a model.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [4:0]  id_rs1, id_rs2;
    logic        id_rs1_used, id_rs2_used;
    logic [31:0] rf_rd1, rf_rd2, id_imm;
    logic [4:0]  id_rd;
    logic        id_rd_we, id_is_load;
    logic [15:0] id_ctrl;
    logic [31:0] ex_alu_y;
    logic [4:0]  mem_rd;
    logic        mem_rd_we;
    logic [31:0] mem_wd;
    logic [4:0]  wb_rd;
    logic        wb_rd_we;
    logic [31:0] wb_wd;
    logic        ex_hold, flush;
    logic        stall, ex_valid, ex_rd_we, ex_is_load;
    logic [31:0] ex_pc, ex_op1, ex_op2, ex_imm;
    logic [4:0]  ex_rd;
    logic [15:0] ex_ctrl;
`ifdef ID_EX_PERF_EN
    logic [31:0] perf_lu_cnt;
`endif

    int checks = 0;
    int errors = 0;

    // Reference state of the EX register
    logic        m_valid, m_rd_we, m_is_load;
    logic [31:0] m_pc, m_op1, m_op2, m_imm, m_perf;
    logic [4:0]  m_rd;
    logic [15:0] m_ctrl;

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk(clk), .rst(rst_n),
        .id_valid(id_valid), .id_pc(id_pc), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .rf_rd1(rf_rd1), .rf_rd2(rf_rd2), .id_imm(id_imm), .id_rd(id_rd),
        .id_rd_we(id_rd_we), .id_is_load(id_is_load), .id_ctrl(id_ctrl),
        .ex_alu_y(ex_alu_y), .mem_rd(mem_rd), .mem_rd_we(mem_rd_we), .mem_wd(mem_wd),
        .wb_rd(wb_rd), .wb_rd_we(wb_rd_we), .wb_wd(wb_wd),
        .ex_hold(ex_hold), .flush(flush), .stall(stall),
        .ex_valid(ex_valid), .ex_rd_we(ex_rd_we), .ex_is_load(ex_is_load),
        .ex_pc(ex_pc), .ex_op1(ex_op1), .ex_op2(ex_op2), .ex_imm(ex_imm),
        .ex_rd(ex_rd), .ex_ctrl(ex_ctrl)
`ifdef ID_EX_PERF_EN
        , .perf_lu_cnt(perf_lu_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_src(input logic [4:0] s, input logic [31:0] rf);
        // Newest in-flight writer of register s supplies its value; x0 is always zero.
        if (s == 0) return 32'd0;
        if (m_valid && m_rd_we && !m_is_load && m_rd == s) return ex_alu_y;
        if (mem_rd_we && mem_rd == s) return mem_wd;
        if (wb_rd_we && wb_rd == s) return wb_wd;
        return rf;
    endfunction

    function automatic logic model_lu();
        if (!(id_valid && m_valid && m_is_load && m_rd_we && m_rd != 0)) return 1'b0;
        return (id_rs1_used && id_rs1 == m_rd) || (id_rs2_used && id_rs2 == m_rd);
    endfunction

    task automatic model_clear();
        m_valid = 0; m_rd_we = 0; m_is_load = 0; m_pc = 0; m_op1 = 0;
        m_op2 = 0; m_imm = 0; m_rd = 0; m_ctrl = 0;
    endtask

    task automatic compare_all(input string tag);
        chk({tag, ".ex_valid"}, 32'(ex_valid), 32'(m_valid));
        chk({tag, ".ex_rd_we"}, 32'(ex_rd_we), 32'(m_rd_we));
        chk({tag, ".ex_is_load"}, 32'(ex_is_load), 32'(m_is_load));
        chk({tag, ".ex_pc"}, ex_pc, m_pc);
        chk({tag, ".ex_op1"}, ex_op1, m_op1);
        chk({tag, ".ex_op2"}, ex_op2, m_op2);
        chk({tag, ".ex_imm"}, ex_imm, m_imm);
        chk({tag, ".ex_rd"}, 32'(ex_rd), 32'(m_rd));
        chk({tag, ".ex_ctrl"}, 32'(ex_ctrl), 32'(m_ctrl));
`ifdef ID_EX_PERF_EN
        chk({tag, ".perf_lu_cnt"}, perf_lu_cnt, m_perf);
`endif
    endtask

    // One clock: check stall, advance the model, clock, compare registered outputs.
    task automatic cycle(input string tag);
        logic        lu;
        logic [31:0] a, b;
        #1;
        lu = model_lu();
        chk({tag, ".stall"}, 32'(stall), 32'(!flush && (ex_hold || lu)));
        a = model_src(id_rs1, rf_rd1);
        b = model_src(id_rs2, rf_rd2);
        if (lu && !flush && !ex_hold) m_perf = m_perf + 1;
        if (flush || (!ex_hold && lu)) model_clear();
        else if (!ex_hold) begin
            m_valid = id_valid; m_rd_we = id_valid & id_rd_we; m_is_load = id_valid & id_is_load;
            m_pc = id_pc; m_op1 = a; m_op2 = b; m_imm = id_imm; m_rd = id_rd; m_ctrl = id_ctrl;
        end
        @(posedge clk);
        #1;
        compare_all(tag);
    endtask

    task automatic set_id(input logic v, input logic [4:0] rs1, input logic u1,
                          input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                          input logic we, input logic ld);
        id_valid = v; id_rs1 = rs1; id_rs1_used = u1; id_rs2 = rs2; id_rs2_used = u2;
        id_rd = rd; id_rd_we = we; id_is_load = ld;
        id_pc = $urandom; id_imm = $urandom; id_ctrl = 16'($urandom);
        rf_rd1 = $urandom; rf_rd2 = $urandom;
    endtask

    task automatic quiet_bypass();
        mem_rd_we = 0; wb_rd_we = 0; mem_rd = 0; wb_rd = 0;
        mem_wd = 0; wb_wd = 0; ex_alu_y = 0;
    endtask

    initial begin
        logic [31:0] held_pc, held_op1;
        rst_n = 0; ex_hold = 0; flush = 0;
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        quiet_bypass();
        model_clear(); m_perf = 0;
        #12;
        compare_all("reset");
        chk("reset.stall", 32'(stall), 32'd0);
        @(negedge clk); rst_n = 1;
        @(posedge clk); #1;

        // Load-use: lw x5 then add x6,x5,x1
        set_id(1, 0, 0, 0, 0, 5, 1, 1);
        cycle("lw_x5");
        set_id(1, 5, 1, 1, 1, 6, 1, 0);
        #1; chk("lu.stall_direct", 32'(stall), 32'd1);
        cycle("lu_bubble");
        chk("lu.bubble_valid", 32'(ex_valid), 32'd0);
        mem_rd = 5; mem_rd_we = 1; mem_wd = 32'hDEADBEEF;
        cycle("lu_resolve");
        chk("lu.op1_memwd", ex_op1, 32'hDEADBEEF);
        quiet_bypass();

        // Bypass priority EX > MEM > WB
        set_id(1, 0, 0, 0, 0, 3, 1, 0);
        cycle("addi_x3");
        set_id(1, 3, 1, 0, 0, 7, 1, 0);
        rf_rd1 = 32'h40; ex_alu_y = 32'h10;
        mem_rd = 3; mem_rd_we = 1; mem_wd = 32'h20;
        wb_rd = 3; wb_rd_we = 1; wb_wd = 32'h30;
        cycle("fwd_ex");
        chk("fwd.ex", ex_op1, 32'h10);
        cycle("fwd_mem");
        chk("fwd.mem", ex_op1, 32'h20);
        mem_rd_we = 0;
        cycle("fwd_wb");
        chk("fwd.wb", ex_op1, 32'h30);
        quiet_bypass();

        // x0 never forwarded, a load to x0 never stalls
        set_id(1, 0, 0, 0, 0, 0, 1, 1);
        cycle("lw_x0");
        set_id(1, 0, 1, 0, 1, 8, 1, 0);
        rf_rd1 = 32'h55; wb_rd = 0; wb_rd_we = 1; wb_wd = 32'hFFFFFFFF;
        #1; chk("x0.stall", 32'(stall), 32'd0);
        cycle("x0_read");
        chk("x0.op1", ex_op1, 32'd0);
        quiet_bypass();

        // Flush overrides load-use
        set_id(1, 0, 0, 0, 0, 5, 1, 1);
        cycle("lw_x5_b");
        set_id(1, 5, 1, 0, 0, 9, 1, 0);
        flush = 1;
        #1; chk("flush.stall", 32'(stall), 32'd0);
        cycle("flush");
        chk("flush.valid", 32'(ex_valid), 32'd0);
        chk("flush.rd_we", 32'(ex_rd_we), 32'd0);
        flush = 0;

        // ex_hold freezes the EX register for 3 cycles
        set_id(1, 1, 1, 2, 1, 10, 1, 0);
        cycle("pre_hold");
        held_pc = ex_pc; held_op1 = ex_op1;
        ex_hold = 1;
        for (int i = 0; i < 3; i++) begin
            set_id(1, 5'($urandom_range(0, 31)), 1, 5'($urandom_range(0, 31)), 1, 11, 1, 0);
            #1; chk("hold.stall", 32'(stall), 32'd1);
            cycle("hold");
            chk("hold.pc", ex_pc, held_pc);
            chk("hold.op1", ex_op1, held_op1);
        end
        ex_hold = 0;
        cycle("hold_release");
        chk("release.pc", ex_pc, id_pc);

        // Random traffic with small register indices to provoke hazards often
        for (int n = 0; n < 400; n++) begin
            set_id(1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 3)), 1'($urandom),
                   5'($urandom_range(0, 3)), 1'($urandom), 5'($urandom_range(0, 3)),
                   1'($urandom), 1'($urandom_range(0, 2) == 0));
            ex_alu_y = $urandom; mem_wd = $urandom; wb_wd = $urandom;
            mem_rd = 5'($urandom_range(0, 3)); mem_rd_we = 1'($urandom);
            wb_rd = 5'($urandom_range(0, 3)); wb_rd_we = 1'($urandom);
            ex_hold = ($urandom_range(0, 7) == 0);
            flush = ($urandom_range(0, 9) == 0);
            cycle("rand");
        end
        ex_hold = 0; flush = 0;
        quiet_bypass();

        // Asynchronous reset mid-stream
        set_id(1, 0, 0, 0, 0, 12, 1, 0);
        cycle("pre_reset");
        chk("pre_reset.valid", 32'(ex_valid), 32'd1);
        ex_hold = 1;
        #3 rst_n = 0;
        #1;
        model_clear(); m_perf = 0;
        compare_all("async_reset");
        chk("async_reset.stall", 32'(stall), 32'd0);
        ex_hold = 0;
        @(negedge clk); rst_n = 1;
        set_id(1, 0, 0, 0, 0, 13, 1, 0);
        cycle("post_reset");
        chk("post_reset.valid", 32'(ex_valid), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
